// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    LAP    = 2'd2,
    PAUSED = 2'd3
  } sw_state_e;

  localparam logic [3:0] DIG_MAX9 = 4'd9;
  localparam logic [3:0] DIG_MAX5 = 4'd5;

  // Most significant digit first, so the packed vector reads MMSSt.
  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
    logic [3:0] tenths;
  } sw_time_t;

  localparam sw_time_t TIME_ZERO = '0;

  function automatic logic time_is_max(input sw_time_t t);
    return (t.min_t == DIG_MAX5) && (t.min_o == DIG_MAX9) &&
           (t.sec_t == DIG_MAX5) && (t.sec_o == DIG_MAX9) &&
           (t.tenths == DIG_MAX9);
  endfunction

endpackage

// File: rtl/bcd_mod_cnt.sv
// One modulo-MOD BCD digit of a ripple-enable counter chain.
module bcd_mod_cnt #(
  parameter int unsigned MOD = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] digit,
  output logic       carry
);

  localparam logic [3:0] LAST = 4'(MOD - 1);

  logic [3:0] r_digit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digit <= '0;
    end else if (clr) begin
      r_digit <= '0;
    end else if (en) begin
      r_digit <= (r_digit == LAST) ? 4'd0 : r_digit + 4'd1;
    end
  end

  assign digit = r_digit;
  assign carry = en & (r_digit == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button edge detection, IDLE/RUN/LAP/PAUSED FSM,
// MM:SS.t BCD timekeeping, lap capture and a registered display mux.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter bit HOLD_AT_MAX = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  output logic       div_clr,
  output logic [3:0] disp_tenths,
  output logic [7:0] disp_sec,
  output logic [7:0] disp_min,
  output logic       running,
  output logic       lap_frozen,
  output logic       ovf
);

  sw_state_e r_state;
  sw_state_e w_state_nxt;

  logic r_ss_q, r_lap_q, r_clr_q;
  logic w_press_ss, w_press_lap, w_press_clr;
  logic w_start, w_capture, w_clear;
  logic w_counting, w_at_max, w_hold, w_cnt_en;

  logic [3:0] w_tenths, w_sec_o, w_sec_t, w_min_o, w_min_t;
  logic       w_c_tenths, w_c_sec_o, w_c_sec_t, w_c_min_o, w_unused_wrap;

  sw_time_t w_live;
  sw_time_t r_lap;
  sw_time_t r_disp;
  logic     r_ovf;
  logic     r_div_clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ss_q  <= 1'b0;
      r_lap_q <= 1'b0;
      r_clr_q <= 1'b0;
    end else begin
      r_ss_q  <= btn_ss;
      r_lap_q <= btn_lap;
      r_clr_q <= btn_clr;
    end
  end

  assign w_press_ss  = btn_ss  & ~r_ss_q;
  assign w_press_lap = btn_lap & ~r_lap_q;
  assign w_press_clr = btn_clr & ~r_clr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Presses a state ignores fall through, so the highest-priority press that
  // is meaningful in the current state is the one that acts.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_press_ss) begin
          w_state_nxt = RUN;
          w_start     = 1'b1;
        end
      end
      RUN: begin
        if (w_press_ss) begin
          w_state_nxt = PAUSED;
        end else if (w_press_lap) begin
          w_state_nxt = LAP;
          w_capture   = 1'b1;
        end
      end
      LAP: begin
        if (w_press_ss) begin
          w_state_nxt = PAUSED;
        end else if (w_press_lap) begin
          w_state_nxt = RUN;
        end
      end
      PAUSED: begin
        if (w_press_clr) begin
          w_state_nxt = IDLE;
          w_clear     = 1'b1;
        end else if (w_press_ss) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counting follows the pre-edge state, so a tick that coincides with a
  // pause press is still counted.
  assign w_counting = (r_state == RUN) || (r_state == LAP);
  assign w_at_max   = time_is_max(w_live);
  assign w_hold     = HOLD_AT_MAX && w_at_max;
  assign w_cnt_en   = tick && w_counting && !w_hold;

  bcd_mod_cnt #(.MOD(10)) u_tenths (
    .clk   (clk),
    .reset (reset),
    .en    (w_cnt_en),
    .clr   (w_clear),
    .digit (w_tenths),
    .carry (w_c_tenths)
  );

  bcd_mod_cnt #(.MOD(10)) u_sec_o (
    .clk   (clk),
    .reset (reset),
    .en    (w_c_tenths),
    .clr   (w_clear),
    .digit (w_sec_o),
    .carry (w_c_sec_o)
  );

  bcd_mod_cnt #(.MOD(6)) u_sec_t (
    .clk   (clk),
    .reset (reset),
    .en    (w_c_sec_o),
    .clr   (w_clear),
    .digit (w_sec_t),
    .carry (w_c_sec_t)
  );

  bcd_mod_cnt #(.MOD(10)) u_min_o (
    .clk   (clk),
    .reset (reset),
    .en    (w_c_sec_t),
    .clr   (w_clear),
    .digit (w_min_o),
    .carry (w_c_min_o)
  );

  // The minutes-tens carry-out is the 59:59.9 rollover; nothing consumes it.
  bcd_mod_cnt #(.MOD(6)) u_min_t (
    .clk   (clk),
    .reset (reset),
    .en    (w_c_min_o),
    .clr   (w_clear),
    .digit (w_min_t),
    .carry (w_unused_wrap)
  );

  assign w_live = {w_min_t, w_min_o, w_sec_t, w_sec_o, w_tenths};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lap     <= TIME_ZERO;
      r_disp    <= TIME_ZERO;
      r_ovf     <= 1'b0;
      r_div_clr <= 1'b0;
    end else begin
      r_div_clr <= w_start;
      r_disp    <= (r_state == LAP) ? r_lap : w_live;
      if (w_clear) begin
        r_lap <= TIME_ZERO;
      end else if (w_capture) begin
        r_lap <= w_live;
      end
      if (w_clear) begin
        r_ovf <= 1'b0;
      end else if (tick && w_counting && w_hold) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign div_clr     = r_div_clr;
  assign disp_tenths = r_disp.tenths;
  assign disp_sec    = {r_disp.sec_t, r_disp.sec_o};
  assign disp_min    = {r_disp.min_t, r_disp.min_o};
  assign running     = w_counting;
  assign lap_frozen  = (r_state == LAP);
  assign ovf         = r_ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: wrap and saturate variants share
// stimulus and are compared against an integer-time reference model.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic btn_ss = 1'b0;
  logic btn_lap = 1'b0;
  logic btn_clr = 1'b0;

  logic       div_clr0, running0, lap_frozen0, ovf0;
  logic [3:0] disp_tenths0;
  logic [7:0] disp_sec0, disp_min0;
  logic       div_clr1, running1, lap_frozen1, ovf1;
  logic [3:0] disp_tenths1;
  logic [7:0] disp_sec1, disp_min1;

  // Observation word: {div_clr, running, lap_frozen, ovf, MM, SS, t}
  logic [23:0] obs0, obs1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.HOLD_AT_MAX(1'b0)) u_dut_wrap (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .btn_ss      (btn_ss),
    .btn_lap     (btn_lap),
    .btn_clr     (btn_clr),
    .div_clr     (div_clr0),
    .disp_tenths (disp_tenths0),
    .disp_sec    (disp_sec0),
    .disp_min    (disp_min0),
    .running     (running0),
    .lap_frozen  (lap_frozen0),
    .ovf         (ovf0)
  );

  stopwatch_ctrl #(.HOLD_AT_MAX(1'b1)) u_dut_hold (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .btn_ss      (btn_ss),
    .btn_lap     (btn_lap),
    .btn_clr     (btn_clr),
    .div_clr     (div_clr1),
    .disp_tenths (disp_tenths1),
    .disp_sec    (disp_sec1),
    .disp_min    (disp_min1),
    .running     (running1),
    .lap_frozen  (lap_frozen1),
    .ovf         (ovf1)
  );

  assign obs0 = {div_clr0, running0, lap_frozen0, ovf0, disp_min0, disp_sec0, disp_tenths0};
  assign obs1 = {div_clr1, running1, lap_frozen1, ovf1, disp_min1, disp_sec1, disp_tenths1};

  // Reference model: time held as a plain count of tenths since zero.
  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSED = 3;
  localparam int MAX_T = 59 * 600 + 59 * 10 + 9;

  int m_state;
  int m_cnt  [2];
  int m_lap  [2];
  int m_disp [2];
  bit m_ovf  [2];
  bit m_div;
  bit q_ss, q_lap, q_clr;

  function automatic logic [19:0] to_bcd(input int n);
    int m, s, t;
    m = n / 600;
    s = (n / 10) % 60;
    t = n % 10;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(t)};
  endfunction

  function automatic logic [23:0] model_obs(input int v);
    bit run_o, lap_o;
    run_o = (m_state == M_RUN) || (m_state == M_LAP);
    lap_o = (m_state == M_LAP);
    return {m_div, run_o, lap_o, m_ovf[v], to_bcd(m_disp[v])};
  endfunction

  function automatic void model_reset();
    m_state = M_IDLE;
    m_div = 1'b0;
    q_ss = 1'b0;
    q_lap = 1'b0;
    q_clr = 1'b0;
    for (int v = 0; v < 2; v++) begin
      m_cnt[v] = 0;
      m_lap[v] = 0;
      m_disp[v] = 0;
      m_ovf[v] = 1'b0;
    end
  endfunction

  function automatic void model_step(input bit t, input bit s, input bit l, input bit c);
    bit p_ss, p_lap, p_clr, adv;
    int nxt;
    int pre [2];
    p_ss  = s & ~q_ss;
    p_lap = l & ~q_lap;
    p_clr = c & ~q_clr;
    q_ss  = s;
    q_lap = l;
    q_clr = c;
    adv = t && (m_state == M_RUN || m_state == M_LAP);
    m_div = (m_state == M_IDLE) && p_ss;
    for (int v = 0; v < 2; v++) begin
      pre[v] = m_cnt[v];
      m_disp[v] = (m_state == M_LAP) ? m_lap[v] : m_cnt[v];
      if (adv) begin
        if (m_cnt[v] < MAX_T) m_cnt[v] = m_cnt[v] + 1;
        else if (v == 1) m_ovf[v] = 1'b1;
        else m_cnt[v] = 0;
      end
    end
    nxt = m_state;
    case (m_state)
      M_IDLE: if (p_ss) nxt = M_RUN;
      M_RUN: begin
        if (p_ss) nxt = M_PAUSED;
        else if (p_lap) begin
          nxt = M_LAP;
          for (int v = 0; v < 2; v++) m_lap[v] = pre[v];
        end
      end
      M_LAP: begin
        if (p_ss) nxt = M_PAUSED;
        else if (p_lap) nxt = M_RUN;
      end
      default: begin
        if (p_clr) begin
          nxt = M_IDLE;
          for (int v = 0; v < 2; v++) begin
            m_cnt[v] = 0;
            m_lap[v] = 0;
            m_ovf[v] = 1'b0;
          end
        end else if (p_ss) nxt = M_RUN;
      end
    endcase
    m_state = nxt;
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h ({div,run,lap,ovf} MMSSt)", name, $time, act, exp);
    end
  endtask

  // Drive at the falling edge, let one rising edge pass, compare at the next falling edge.
  task automatic cycle(input bit t, input bit s, input bit l, input bit c);
    tick = t;
    btn_ss = s;
    btn_lap = l;
    btn_clr = c;
    @(posedge clk);
    model_step(t, s, l, c);
    @(negedge clk);
    check("model wrap", obs0, model_obs(0));
    check("model hold", obs1, model_obs(1));
  endtask

  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    tick = 1'b0;
    btn_ss = 1'b0;
    btn_lap = 1'b0;
    btn_clr = 1'b0;
    #1;
    check({tag, " reset wrap"}, obs0, 24'h0);
    check({tag, " reset hold"}, obs1, 24'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct packed {
    bit          tick;
    bit          ss;
    bit          lap;
    bit          clr;
    bit          div;
    bit          run;
    bit          lapf;
    logic [19:0] disp;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int n_tr;
    bit prev_run;
    bit rs, rl, rc;

    // tick ss lap clr | div run lapf disp
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 20'h00000};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 20'h00000};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 20'h00001};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 20'h00002};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'h00002};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'h00002};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20'h00002};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 20'h00004};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20'h00004};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00004};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00005};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00005};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00000};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00000};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 20'h00000};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 20'h00000};

    do_reset("power-on");

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].tick, tbl[i].ss, tbl[i].lap, tbl[i].clr);
      check($sformatf("table[%0d]", i), obs0,
            {tbl[i].div, tbl[i].run, tbl[i].lapf, 1'b0, tbl[i].disp});
    end

    // Start, ten tenths: one-cycle div_clr then 00:01.0.
    do_reset("start");
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("start div_clr high", obs0, {1'b1, 1'b1, 1'b0, 1'b0, 20'h00000});
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("start div_clr one cycle", obs0, {1'b0, 1'b1, 1'b0, 1'b0, 20'h00000});
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("ten ticks 00:01.0", obs0, {1'b0, 1'b1, 1'b0, 1'b0, 20'h00010});

    // Lap freeze at 00:05.3 while the live count runs on to 00:07.3.
    for (int i = 0; i < 43; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("lap frozen 00:05.3", obs0, {1'b0, 1'b1, 1'b1, 1'b0, 20'h00053});
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("lap release 00:07.3", obs0, {1'b0, 1'b1, 1'b0, 1'b0, 20'h00073});

    // Tick and stop on the same edge: the tick still counts.
    do_reset("tick+ss");
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("pause with tick 00:00.5", obs0, {1'b0, 1'b0, 1'b0, 1'b0, 20'h00005});
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("paused ignores ticks", obs0, {1'b0, 1'b0, 1'b0, 1'b0, 20'h00005});
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check("clr beats ss, no div_clr", obs0, {1'b0, 1'b0, 1'b0, 1'b0, 20'h00005});
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("cleared 00:00.0", obs0, 24'h0);

    // Run up to 59:59.9, then one more tick in each variant.
    do_reset("max");
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < MAX_T; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("at max wrap", obs0, {1'b0, 1'b1, 1'b0, 1'b0, 20'h59599});
    check("at max hold", obs1, {1'b0, 1'b1, 1'b0, 1'b0, 20'h59599});
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap to zero", obs0, {1'b0, 1'b1, 1'b0, 1'b0, 20'h00000});
    check("hold saturates", obs1, {1'b0, 1'b1, 1'b0, 1'b1, 20'h59599});
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf sticky in pause", obs1, {1'b0, 1'b0, 1'b0, 1'b1, 20'h59599});
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("clr drops ovf", obs1, 24'h0);

    // A held start/stop level is one press only.
    do_reset("hold ss");
    n_tr = 0;
    prev_run = running0;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      if (running0 !== prev_run) n_tr++;
      prev_run = running0;
    end
    check("held ss transitions", 24'(n_tr), 24'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-run clears at once; ticks alone do not restart counting.
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset("mid-run");
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("no restart without ss", obs0, 24'h0);

    do_reset("random");
    rs = 1'b0;
    rl = 1'b0;
    rc = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) rs = ~rs;
      if ($urandom_range(0, 7) == 0) rl = ~rl;
      if ($urandom_range(0, 11) == 0) rc = ~rc;
      cycle($urandom_range(0, 2) == 0, rs, rl, rc);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control and timekeeping block for the sub-second stopwatch.
- Consumes the single-cycle 10 Hz enable pulse from the tenth-second divider chain and counts MM:SS.t in BCD.
- Decodes start/stop, lap and clear buttons through a 4-state FSM.
- Drives a one-cycle divider-clear pulse so the first tenth after a fresh start has full length.

Parameters:
HOLD_AT_MAX, 0, 0 = wrap 59:59.9 to 00:00.0; 1 = saturate at 59:59.9 and set ovf

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
tick  in  1  1-cycle enable pulse from the 10 Hz divider chain
btn_ss  in  1  start/stop button level, already synchronised and debounced
btn_lap  in  1  lap button level, already synchronised and debounced
btn_clr  in  1  clear button level, already synchronised and debounced
div_clr  out  1  1-cycle pulse that resets the divider chain
disp_tenths  out  4  BCD tenths digit shown on the display
disp_sec  out  8  two BCD digits, seconds 00..59
disp_min  out  8  two BCD digits, minutes 00..59
running  out  1  high in RUN or LAP
lap_frozen  out  1  high in LAP
ovf  out  1  sticky overflow flag; only set when HOLD_AT_MAX=1

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk.
- Reset values:
  - FSM in IDLE.
  - All count and lap registers 0.
  - All outputs 0.
  - Button history registers 0.
- Press detection:
  - press_x = btn_x & ~btn_x_q, where btn_x_q is the button registered each clk.
  - One press per rising edge of the level.
  - A held button produces no repeats.
- Priority when presses coincide: clr > ss > lap. Only the highest-priority valid press acts.
- FSM states: IDLE, RUN, LAP, PAUSED. All transitions take effect at the clk edge where the press is detected.
  - IDLE: ss -> RUN and assert div_clr for exactly that one cycle. lap and clr are ignored.
  - RUN: ss -> PAUSED. lap -> LAP and copy the live count into the lap registers. clr is ignored.
  - LAP: lap -> RUN. ss -> PAUSED. clr is ignored. The live count keeps advancing.
  - PAUSED: ss -> RUN, with no div_clr. clr -> IDLE, clearing the count, lap registers and ovf. lap is ignored.
- Counting:
  - The live count advances at an edge where tick=1 and the current state is RUN or LAP.
  - This applies even if a press at the same edge changes the state.
  - A tick coinciding with ss in RUN is counted, then the FSM pauses.
- Carry chain:
  - tenths 9 -> 0 carries into seconds-ones.
  - seconds-ones 9 -> 0 carries into seconds-tens.
  - seconds-tens 5 -> 0 carries into minutes-ones.
  - The same pattern continues through minutes.
  - Digits never hold a non-BCD value, and never hold a tens value above 5.
- Maximum count 59:59.9 plus a tick:
  - HOLD_AT_MAX=0: count goes to 00:00.0; ovf stays 0.
  - HOLD_AT_MAX=1: count holds at 59:59.9 and ovf becomes 1. ovf stays 1 until clr in PAUSED or reset.
- Display selection:
  - disp_* shows the lap registers in LAP.
  - disp_* shows the live count in all other states.
  - Display outputs are registered, so they lag the count or state update by one clk.
- running and lap_frozen are decoded directly from the state register. They are valid in the same cycle as the state.
- Reset asserted mid-operation returns everything to reset values immediately. Counting restarts only after a new ss press.

Decomposition:
- Package stopwatch_pkg holds:
  - state enum {IDLE, RUN, LAP, PAUSED}.
  - BCD constants: DIG_MAX9 = 4'd9, DIG_MAX5 = 4'd5.
  - Time record typedef: tenths, sec_o, sec_t, min_o, min_t.
- One sub-module, bcd_mod_cnt:
  - Parameter MOD.
  - Inputs reset, clk, en, clr.
  - Outputs digit[3:0] and carry, where carry = en & (digit == MOD-1).
  - Instantiated five times: MOD 10, 10, 6, 10, 6.

Test Plan:
- Reset, pulse btn_ss, apply 10 ticks -> div_clr high for exactly 1 cycle at the press edge; display 00:01.0; running=1.
- RUN at 00:05.3, press btn_lap, apply 20 ticks -> lap_frozen=1; display stays 00:05.3. Press btn_lap again -> display 00:07.3.
- RUN, tick and btn_ss rising at the same edge from 00:00.4 -> state PAUSED; display 00:00.5. Further ticks leave it at 00:00.5.
- PAUSED, press btn_clr and btn_ss at the same edge -> IDLE; display 00:00.0; no div_clr. Clear while RUN -> ignored.
- Preload to 59:59.9 via 35999 ticks, then 1 tick:
  - HOLD_AT_MAX=0 -> 00:00.0, ovf=0.
  - HOLD_AT_MAX=1 -> 59:59.9, ovf=1, cleared by clr in PAUSED.
- Hold btn_ss high for 100 cycles -> exactly one transition. Assert reset mid-RUN -> all outputs 0 immediately.
